// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for I-fetch and D-access with one transaction in flight,
// D-priority plus an I-starvation guard, and a watchdog that aborts hung transactions.
module mem_arbiter #(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                i_req_i,
    input  logic [ADDR_W-1:0]   i_addr_i,
    output logic                i_ready_o,
    output logic                i_rvalid_o,
    output logic [DATA_W-1:0]   i_rdata_o,
    input  logic                d_req_i,
    input  logic                d_we_i,
    input  logic [ADDR_W-1:0]   d_addr_i,
    input  logic [DATA_W-1:0]   d_wdata_i,
    input  logic [DATA_W/8-1:0] d_wstrb_i,
    output logic                d_ready_o,
    output logic                d_rvalid_o,
    output logic [DATA_W-1:0]   d_rdata_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_wstrb_o,
    input  logic                mem_ready_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                fetch_stall_o,
    output logic                mem_stall_o,
    output logic                err_o
);
    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam int WW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

    state_t              r_state, w_next;
    logic                r_owner_d;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_wstrb;
    logic [SW-1:0]       r_streak;
    logic [WW-1:0]       r_wdog;
    logic                r_err;
    logic                r_i_rvalid, r_d_rvalid;
    logic [DATA_W-1:0]   r_i_rdata, r_d_rdata;

    logic w_idle, w_d_win, w_grant_d, w_grant_i, w_grant;
    logic w_timeout, w_done;

    // D wins unless I has been passed over MAX_D_STREAK times in a row
    assign w_idle    = (r_state == S_IDLE);
    assign w_d_win   = d_req_i & ~(i_req_i & (r_streak == SW'(MAX_D_STREAK)));
    assign w_grant_d = w_idle & w_d_win;
    assign w_grant_i = w_idle & i_req_i & ~w_d_win;
    assign w_grant   = w_grant_d | w_grant_i;

    // Completion in the final watchdog cycle takes precedence over the abort
    assign w_timeout = ~w_idle & (r_wdog == WW'(TIMEOUT - 1));
    assign w_done    = (r_state == S_RESP) & mem_rvalid_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_grant) w_next = S_REQ;
            S_REQ: begin
                if (w_timeout)        w_next = S_IDLE;
                else if (mem_ready_i) w_next = S_RESP;
            end
            S_RESP: if (w_done || w_timeout) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        i_ready_o = w_grant_i;
        d_ready_o = w_grant_d;
        mem_req_o = (r_state == S_REQ) & ~w_timeout;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_owner_d  <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_streak   <= '0;
            r_wdog     <= '0;
            r_err      <= 1'b0;
            r_i_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            r_i_rdata  <= '0;
            r_d_rdata  <= '0;
        end else begin
            r_i_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            if (w_grant) begin
                r_owner_d <= w_grant_d;
                r_we      <= w_grant_d & d_we_i;
                r_addr    <= w_grant_d ? d_addr_i : i_addr_i;
                r_wdata   <= w_grant_d ? d_wdata_i : '0;
                r_wstrb   <= (w_grant_d & d_we_i) ? d_wstrb_i : '0;
                r_wdog    <= '0;
            end else if (!w_idle) begin
                r_wdog <= r_wdog + 1'b1;
            end
            if (w_grant_i)
                r_streak <= '0;
            else if (w_grant_d && i_req_i && r_streak != SW'(MAX_D_STREAK))
                r_streak <= r_streak + 1'b1;
            if (w_done) begin
                if (r_owner_d) begin r_d_rvalid <= 1'b1; r_d_rdata <= mem_rdata_i; end
                else           begin r_i_rvalid <= 1'b1; r_i_rdata <= mem_rdata_i; end
            end else if (w_timeout) begin
                r_err <= 1'b1;
                if (r_owner_d) begin r_d_rvalid <= 1'b1; r_d_rdata <= '0; end
                else           begin r_i_rvalid <= 1'b1; r_i_rdata <= '0; end
            end
        end
    end

    assign mem_we_o      = r_we;
    assign mem_addr_o    = r_addr;
    assign mem_wdata_o   = r_wdata;
    assign mem_wstrb_o   = r_wstrb;
    assign i_rvalid_o    = r_i_rvalid;
    assign i_rdata_o     = r_i_rdata;
    assign d_rvalid_o    = r_d_rvalid;
    assign d_rdata_o     = r_d_rdata;
    assign err_o         = r_err;
    assign fetch_stall_o = i_req_i & ~r_i_rvalid;
    assign mem_stall_o   = d_req_i & ~r_d_rvalid;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grant priority, streak guard, backpressure,
// watchdog abort and reset mid-transaction.
module tb_mem_arbiter;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int BW = DW / 8;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          i_req_i;
    logic [AW-1:0] i_addr_i;
    logic          i_ready_o, i_rvalid_o;
    logic [DW-1:0] i_rdata_o;
    logic          d_req_i, d_we_i;
    logic [AW-1:0] d_addr_i;
    logic [DW-1:0] d_wdata_i;
    logic [BW-1:0] d_wstrb_i;
    logic          d_ready_o, d_rvalid_o;
    logic [DW-1:0] d_rdata_o;
    logic          mem_req_o, mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [BW-1:0] mem_wstrb_o;
    logic          mem_ready_i, mem_rvalid_i;
    logic [DW-1:0] mem_rdata_i;
    logic          fetch_stall_o, mem_stall_o, err_o;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(4), .TIMEOUT(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_ready_o(i_ready_o),
        .i_rvalid_o(i_rvalid_o), .i_rdata_o(i_rdata_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i),
        .d_wdata_i(d_wdata_i), .d_wstrb_i(d_wstrb_i), .d_ready_o(d_ready_o),
        .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
        .mem_ready_i(mem_ready_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .fetch_stall_o(fetch_stall_o), .mem_stall_o(mem_stall_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clr_inputs();
        i_req_i = 0; i_addr_i = '0;
        d_req_i = 0; d_we_i = 0; d_addr_i = '0; d_wdata_i = '0; d_wstrb_i = '0;
        mem_ready_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
    endtask

    task automatic test_reset();
        logic [7:0] flags;
        rst_i = 1; clr_inputs();
        tick(); tick(); #1;
        flags = {i_ready_o, i_rvalid_o, d_ready_o, d_rvalid_o, mem_req_o, mem_we_o, err_o, fetch_stall_o | mem_stall_o};
        total++; if (flags !== 8'h0) begin bad++; $display("FAIL reset_flags got=%0h exp=0", flags); end
        total++; if ({i_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o, mem_wstrb_o} !== '0) begin
            bad++; $display("FAIL reset_fields got=%0h/%0h/%0h exp=0", i_rdata_o, d_rdata_o, mem_addr_o); end
        rst_i = 0; tick();
    endtask

    task automatic test_i_only();
        i_req_i = 1; i_addr_i = 64'h1000; mem_ready_i = 1; #1;
        total++; if ({i_ready_o, d_ready_o, fetch_stall_o} !== 3'b101) begin
            bad++; $display("FAIL ionly_grant got=%b exp=101", {i_ready_o, d_ready_o, fetch_stall_o}); end
        tick(); #1;
        total++; if ({mem_req_o, mem_we_o, mem_wstrb_o} !== {2'b10, 8'h00} || mem_addr_o !== 64'h1000) begin
            bad++; $display("FAIL ionly_memreq got=%b/%0h addr=%0h exp=1/0 addr=1000", mem_req_o, mem_wstrb_o, mem_addr_o); end
        tick(); mem_rvalid_i = 1; mem_rdata_i = 64'hDEAD; #1;
        total++; if ({mem_req_o, i_rvalid_o} !== 2'b00) begin
            bad++; $display("FAIL ionly_resp got=%b exp=00", {mem_req_o, i_rvalid_o}); end
        tick(); mem_rvalid_i = 0; i_req_i = 0; #1;
        total++; if (i_rvalid_o !== 1'b1 || i_rdata_o !== 64'hDEAD) begin
            bad++; $display("FAIL ionly_rvalid got=%b/%0h exp=1/dead", i_rvalid_o, i_rdata_o); end
        tick(); #1;
        total++; if (i_rvalid_o !== 1'b0 || i_rdata_o !== 64'hDEAD) begin
            bad++; $display("FAIL ionly_hold got=%b/%0h exp=0/dead", i_rvalid_o, i_rdata_o); end
    endtask

    task automatic test_d_priority();
        i_req_i = 1; i_addr_i = 64'h1100;
        d_req_i = 1; d_we_i = 1; d_addr_i = 64'h2000; d_wdata_i = 64'h1234_5678; d_wstrb_i = 8'h0F;
        mem_ready_i = 1; #1;
        total++; if ({d_ready_o, i_ready_o} !== 2'b10) begin
            bad++; $display("FAIL dprio_grant got=%b exp=10", {d_ready_o, i_ready_o}); end
        tick(); d_req_i = 0; #1;
        total++; if ({mem_req_o, mem_we_o} !== 2'b11 || mem_wstrb_o !== 8'h0F || mem_addr_o !== 64'h2000 || mem_wdata_o !== 64'h1234_5678) begin
            bad++; $display("FAIL dprio_store got=%b strb=%0h addr=%0h wd=%0h exp=11 0f 2000 12345678", {mem_req_o, mem_we_o}, mem_wstrb_o, mem_addr_o, mem_wdata_o); end
        tick(); mem_rvalid_i = 1; mem_rdata_i = 64'hACE;
        tick(); mem_rvalid_i = 0; #1;
        total++; if ({d_rvalid_o, i_rvalid_o, i_ready_o} !== 3'b101 || d_rdata_o !== 64'hACE) begin
            bad++; $display("FAIL dprio_ack got=%b/%0h exp=101/ace", {d_rvalid_o, i_rvalid_o, i_ready_o}, d_rdata_o); end
        tick(); #1;
        total++; if ({mem_req_o, mem_we_o, mem_wstrb_o} !== {2'b10, 8'h00} || mem_addr_o !== 64'h1100) begin
            bad++; $display("FAIL dprio_ireq got=%b/%0h addr=%0h exp=10/0 addr=1100", {mem_req_o, mem_we_o}, mem_wstrb_o, mem_addr_o); end
        tick(); mem_rvalid_i = 1; mem_rdata_i = 64'hBEEF;
        tick(); mem_rvalid_i = 0; i_req_i = 0; #1;
        total++; if ({i_rvalid_o, d_rvalid_o} !== 2'b10 || i_rdata_o !== 64'hBEEF) begin
            bad++; $display("FAIL dprio_irsp got=%b/%0h exp=10/beef", {i_rvalid_o, d_rvalid_o}, i_rdata_o); end
        tick();
    endtask

    task automatic test_streak();
        logic exp_d, prev_d;
        logic [DW-1:0] got;
        prev_d = 0;
        for (int s = 0; s < 10; s++) begin
            exp_d = ((s % 5) != 4);
            d_req_i = 1; d_we_i = 0; d_addr_i = 64'h5000 + AW'(s);
            i_req_i = 1; i_addr_i = 64'h6000 + AW'(s); mem_ready_i = 1; #1;
            total++; if ({d_ready_o, i_ready_o} !== {exp_d, ~exp_d}) begin
                bad++; $display("FAIL streak_grant%0d got=%b exp=%b", s, {d_ready_o, i_ready_o}, {exp_d, ~exp_d}); end
            if (s > 0) begin
                got = prev_d ? d_rdata_o : i_rdata_o;
                total++; if ({d_rvalid_o, i_rvalid_o} !== {prev_d, ~prev_d} || got !== DW'(s - 1)) begin
                    bad++; $display("FAIL streak_rsp%0d got=%b/%0h exp=%b/%0h", s, {d_rvalid_o, i_rvalid_o}, got, {prev_d, ~prev_d}, s - 1); end
            end
            tick(); tick(); mem_rvalid_i = 1; mem_rdata_i = DW'(s);
            tick(); mem_rvalid_i = 0;
            prev_d = exp_d;
        end
        d_req_i = 0; i_req_i = 0; #1;
        total++; if (i_rvalid_o !== 1'b1 || i_rdata_o !== 64'd9) begin
            bad++; $display("FAIL streak_last got=%b/%0h exp=1/9", i_rvalid_o, i_rdata_o); end
        tick();
    endtask

    task automatic test_backpressure();
        d_req_i = 1; d_we_i = 0; d_addr_i = 64'h3000; d_wdata_i = 64'hFACE; mem_ready_i = 0; #1;
        total++; if (d_ready_o !== 1'b1) begin bad++; $display("FAIL bp_grant got=%b exp=1", d_ready_o); end
        for (int k = 0; k < 5; k++) begin
            tick(); #1;
            total++; if ({mem_req_o, mem_we_o, mem_stall_o} !== 3'b101 || mem_addr_o !== 64'h3000 || mem_wdata_o !== 64'hFACE) begin
                bad++; $display("FAIL bp_hold%0d got=%b addr=%0h wd=%0h exp=101 3000 face", k, {mem_req_o, mem_we_o, mem_stall_o}, mem_addr_o, mem_wdata_o); end
        end
        tick(); mem_ready_i = 1; #1;
        tick(); mem_ready_i = 0; mem_rvalid_i = 1; mem_rdata_i = 64'h3333; #1;
        total++; if ({mem_req_o, d_rvalid_o} !== 2'b00) begin
            bad++; $display("FAIL bp_early got=%b exp=00", {mem_req_o, d_rvalid_o}); end
        tick(); mem_rvalid_i = 0; d_req_i = 0; #1;
        total++; if (d_rvalid_o !== 1'b1 || d_rdata_o !== 64'h3333) begin
            bad++; $display("FAIL bp_done got=%b/%0h exp=1/3333", d_rvalid_o, d_rdata_o); end
        tick();
    endtask

    task automatic test_timeout();
        i_req_i = 1; i_addr_i = 64'h4000; mem_ready_i = 1; #1;
        total++; if (i_ready_o !== 1'b1) begin bad++; $display("FAIL to_grant got=%b exp=1", i_ready_o); end
        for (int k = 1; k <= 8; k++) tick();
        #1;
        total++; if ({i_rvalid_o, err_o} !== 2'b00) begin
            bad++; $display("FAIL to_early got=%b exp=00", {i_rvalid_o, err_o}); end
        tick(); i_req_i = 0; #1;
        total++; if ({i_rvalid_o, err_o} !== 2'b11 || i_rdata_o !== '0) begin
            bad++; $display("FAIL to_abort got=%b/%0h exp=11/0", {i_rvalid_o, err_o}, i_rdata_o); end
        tick(); mem_rvalid_i = 1; mem_rdata_i = 64'h7777; #1;
        total++; if (i_rvalid_o !== 1'b0) begin bad++; $display("FAIL to_pulse got=%b exp=0", i_rvalid_o); end
        tick(); mem_rvalid_i = 0; #1;
        total++; if ({i_rvalid_o, d_rvalid_o, err_o} !== 3'b001 || i_rdata_o !== '0) begin
            bad++; $display("FAIL to_late got=%b/%0h exp=001/0", {i_rvalid_o, d_rvalid_o, err_o}, i_rdata_o); end
    endtask

    task automatic test_reset_mid();
        d_req_i = 1; d_we_i = 0; d_addr_i = 64'h7000; mem_ready_i = 1; #1;
        tick(); tick(); rst_i = 1; d_req_i = 0; mem_ready_i = 0;
        tick(); #1;
        total++; if ({i_ready_o, d_ready_o, i_rvalid_o, d_rvalid_o, mem_req_o, mem_we_o, err_o} !== 7'b0 ||
                     {i_rdata_o, d_rdata_o, mem_addr_o} !== '0) begin
            bad++; $display("FAIL rstmid_outs got=%b rd=%0h/%0h addr=%0h exp=0", {i_ready_o, d_ready_o, i_rvalid_o, d_rvalid_o, mem_req_o, mem_we_o, err_o}, i_rdata_o, d_rdata_o, mem_addr_o); end
        rst_i = 0; mem_rvalid_i = 1; mem_rdata_i = 64'h9999;
        tick(); mem_rvalid_i = 0; #1;
        total++; if ({d_rvalid_o, i_rvalid_o} !== 2'b00) begin
            bad++; $display("FAIL rstmid_late got=%b exp=00", {d_rvalid_o, i_rvalid_o}); end
        i_req_i = 1; i_addr_i = 64'h8000; mem_ready_i = 1; #1;
        total++; if (i_ready_o !== 1'b1) begin bad++; $display("FAIL rstmid_grant got=%b exp=1", i_ready_o); end
        tick(); #1;
        total++; if (mem_req_o !== 1'b1 || mem_addr_o !== 64'h8000) begin
            bad++; $display("FAIL rstmid_req got=%b/%0h exp=1/8000", mem_req_o, mem_addr_o); end
        tick(); mem_rvalid_i = 1; mem_rdata_i = 64'h88;
        tick(); mem_rvalid_i = 0; i_req_i = 0; #1;
        total++; if (i_rvalid_o !== 1'b1 || i_rdata_o !== 64'h88) begin
            bad++; $display("FAIL rstmid_rsp got=%b/%0h exp=1/88", i_rvalid_o, i_rdata_o); end
        tick();
    endtask

    initial begin
        test_reset();
        test_i_only();
        test_d_priority();
        test_streak();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
